// File: rtl/miriscv_gpr.sv
// RISC-V general-purpose register file: two combinational read ports with write
// bypass, one write port, and a self-clearing sequence after every reset.
module miriscv_gpr #(
  parameter int RISCV_E        = 0,
  parameter int GPR_ADDR_WIDTH = 5 - RISCV_E,
  parameter int GPR_DEPTH      = 2 ** GPR_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      wr_en_i,
  input  logic [GPR_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]               wr_data_i,
  input  logic [GPR_ADDR_WIDTH-1:0] r1_addr_i,
  output logic [31:0]               r1_data_o,
  input  logic [GPR_ADDR_WIDTH-1:0] r2_addr_i,
  output logic [31:0]               r2_data_o,
  output logic                      init_done_o
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [GPR_ADDR_WIDTH-1:0] LAST_IDX = GPR_ADDR_WIDTH'(GPR_DEPTH - 1);

  state_e                    state_q, state_d;
  logic [GPR_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                      init_done_q, init_done_d;

  logic                      mem_we;
  logic [GPR_ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]               mem_wdata;

  // x0 is hard-wired to zero, so the array starts at entry 1.
  logic [31:0] mem_q [GPR_DEPTH-1:1];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr_i;
    mem_wdata   = wr_data_i;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        mem_we = wr_en_i && (wr_addr_i != '0) && (int'(wr_addr_i) < GPR_DEPTH);
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= GPR_ADDR_WIDTH'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: the storage array has no reset; the CLEAR walk is what zeroes it,
  // which keeps the array mappable onto plain flops or a RAM macro.
  always_ff @(posedge clk_i) begin
    if (arstn_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    r1_data_o = '0;
    r2_data_o = '0;
    if (state_q == READY) begin
      if (r1_addr_i != '0 && int'(r1_addr_i) < GPR_DEPTH) begin
        r1_data_o = (wr_en_i && wr_addr_i == r1_addr_i) ? wr_data_i : mem_q[r1_addr_i];
      end
      if (r2_addr_i != '0 && int'(r2_addr_i) < GPR_DEPTH) begin
        r2_data_o = (wr_en_i && wr_addr_i == r2_addr_i) ? wr_data_i : mem_q[r2_addr_i];
      end
    end
  end

  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_miriscv_gpr.sv
// Directed and randomized scoreboard bench for miriscv_gpr in both RV32I and RV32E builds.
module tb_miriscv_gpr;

  logic clk;

  logic        arstn0, wr_en0, init_done0;
  logic [4:0]  wr_addr0, r1_addr0, r2_addr0;
  logic [31:0] wr_data0, r1_data0, r2_data0;

  logic        arstn1, wr_en1, init_done1;
  logic [3:0]  wr_addr1, r1_addr1, r2_addr1;
  logic [31:0] wr_data1, r1_data1, r2_data1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model0 [32];

  miriscv_gpr #(.RISCV_E(0)) dut0 (
    .clk_i(clk), .arstn_i(arstn0), .wr_en_i(wr_en0), .wr_addr_i(wr_addr0),
    .wr_data_i(wr_data0), .r1_addr_i(r1_addr0), .r1_data_o(r1_data0),
    .r2_addr_i(r2_addr0), .r2_data_o(r2_data0), .init_done_o(init_done0)
  );

  miriscv_gpr #(.RISCV_E(1)) dut1 (
    .clk_i(clk), .arstn_i(arstn1), .wr_en_i(wr_en1), .wr_addr_i(wr_addr1),
    .wr_data_i(wr_data1), .r1_addr_i(r1_addr1), .r1_data_o(r1_data1),
    .r2_addr_i(r2_addr1), .r2_data_o(r2_data1), .init_done_o(init_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for the given edges, releases it, then walks the whole clear
  // window of dut0 checking zeroed reads and the exact init_done rise edge.
  // A write of 0xFFFFFFFF to x3 is attempted on clear cycle 5.
  task automatic run_clear0(input int hold_edges, input int abort_at);
    logic [31:0] e;
    @(negedge clk);
    arstn0 = 1'b0;
    wr_en0 = 1'b0;
    repeat (hold_edges) @(posedge clk);
    #1;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if ({31'd0, init_done0} !== e) begin
      errors++;
      $display("FAIL reset_init_done got %0h want %0h", init_done0, e);
    end
    @(negedge clk);
    arstn0   = 1'b1;
    r1_addr0 = 5'd3;
    r2_addr0 = 5'd10;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      if (cyc == abort_at) begin
        arstn0 = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, init_done0} !== e) begin
          errors++;
          $display("FAIL abort_init_done got %0h want %0h", init_done0, e);
        end
        @(negedge clk);
        arstn0 = 1'b1;
        cyc = 0;
        abort_at = 0;
        continue;
      end
      wr_en0   = (cyc == 5);
      wr_addr0 = 5'd3;
      wr_data0 = 32'hFFFF_FFFF;
      #2;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front();
      checks++;
      if (r1_data0 !== e) begin
        errors++;
        $display("FAIL clear_r1 cyc %0d got %0h want %0h", cyc, r1_data0, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (r2_data0 !== e) begin
        errors++;
        $display("FAIL clear_r2 cyc %0d got %0h want %0h", cyc, r2_data0, e);
      end
      @(posedge clk);
      #1;
      if (cyc >= 30) begin
        exp_q.push_back((cyc == 31) ? 32'd1 : 32'd0);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, init_done0} !== e) begin
          errors++;
          $display("FAIL init_done_edge cyc %0d got %0h want %0h", cyc, init_done0, e);
        end
      end
      @(negedge clk);
    end
    wr_en0 = 1'b0;
    for (int i = 0; i < 32; i++) model0[i] = 32'd0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    run_clear0(2, 0);
    for (int i = 1; i < 32; i++) begin
      r1_addr0 = 5'(i);
      r2_addr0 = 5'(32 - i);
      #2;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front();
      checks++;
      if (r1_data0 !== e) begin
        errors++;
        $display("FAIL cleared_r1 x%0d got %0h want %0h", i, r1_data0, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (r2_data0 !== e) begin
        errors++;
        $display("FAIL cleared_r2 x%0d got %0h want %0h", 32 - i, r2_data0, e);
      end
      @(negedge clk);
    end
  endtask

  // Drives one dut0 cycle, pushes model-predicted reads, compares before the
  // edge, then commits the write into the model.
  task automatic cycle0(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2, input string tag);
    logic [31:0] e;
    wr_en0 = we; wr_addr0 = wa; wr_data0 = wd; r1_addr0 = ra1; r2_addr0 = ra2;
    exp_q.push_back((ra1 == 0) ? 32'd0 : (we && wa == ra1) ? wd : model0[ra1]);
    exp_q.push_back((ra2 == 0) ? 32'd0 : (we && wa == ra2) ? wd : model0[ra2]);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (r1_data0 !== e) begin
      errors++;
      $display("FAIL %s_r1 got %0h want %0h", tag, r1_data0, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (r2_data0 !== e) begin
      errors++;
      $display("FAIL %s_r2 got %0h want %0h", tag, r2_data0, e);
    end
    @(posedge clk);
    if (we && wa != 0) model0[wa] = wd;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    cycle0(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, "wr_x5");
    cycle0(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, "rd_x5");
    cycle0(1'b1, 5'd0, 32'h1234_5678, 5'd5, 5'd0, "wr_x0");
    cycle0(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "rd_x0");
    cycle0(1'b1, 5'd31, 32'h8000_0001, 5'd30, 5'd1, "wr_x31");
    cycle0(1'b0, 5'd0, 32'd0, 5'd31, 5'd5, "rd_x31");
  endtask

  task automatic test_bypass;
    cycle0(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, "bypass_x7");
    cycle0(1'b0, 5'd7, 32'h0, 5'd7, 5'd7, "after_bypass_x7");
    cycle0(1'b1, 5'd7, 32'h5A5A_5A5A, 5'd7, 5'd5, "bypass_r1_only");
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic        we;
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = (n % 4 == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = (n % 5 == 0) ? wa : 5'($urandom_range(0, 31));
      cycle0(we, wa, wd, ra1, ra2, "random");
    end
  endtask

  task automatic test_reset_mid_op;
    cycle0(1'b1, 5'd10, 32'h55, 5'd0, 5'd0, "wr_x10");
    cycle0(1'b0, 5'd0, 32'd0, 5'd10, 5'd0, "rd_x10");
    run_clear0(1, 10);
    cycle0(1'b0, 5'd0, 32'd0, 5'd10, 5'd5, "x10_after_reset");
  endtask

  task automatic test_rv32e;
    logic [31:0] e;
    @(negedge clk);
    arstn1 = 1'b0;
    wr_en1 = 1'b0;
    r1_addr1 = 4'd15;
    r2_addr1 = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn1 = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc >= 14) begin
        exp_q.push_back((cyc == 15) ? 32'd1 : 32'd0);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, init_done1} !== e) begin
          errors++;
          $display("FAIL e_init_done cyc %0d got %0h want %0h", cyc, init_done1, e);
        end
      end
    end
    @(negedge clk);
    wr_en1 = 1'b1; wr_addr1 = 4'd15; wr_data1 = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    wr_en1 = 1'b0;
    #2;
    exp_q.push_back(32'hCAFE_F00D);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if (r1_data1 !== e) begin
      errors++;
      $display("FAIL e_x15 got %0h want %0h", r1_data1, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (r2_data1 !== e) begin
      errors++;
      $display("FAIL e_x1 got %0h want %0h", r2_data1, e);
    end
  endtask

  initial begin
    arstn0 = 1'b0; wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; r1_addr0 = '0; r2_addr0 = '0;
    arstn1 = 1'b0; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; r1_addr1 = '0; r2_addr1 = '0;
    test_reset;
    test_write_read;
    test_bypass;
    test_random;
    test_reset_mid_op;
    test_rv32e;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miriscv_gpr.md
MIRISCV_GPR -- requirements
Module: miriscv_gpr

Interface
REQ-001 SHALL have parameter RISCV_E, default 0, meaning 1 selects the RV32E 16-entry register file and 0 selects the RV32I 32-entry register file.
REQ-002 SHALL have parameter GPR_ADDR_WIDTH, default 5-RISCV_E, meaning register address width.
REQ-003 SHALL have parameter GPR_DEPTH, default 2**GPR_ADDR_WIDTH, meaning number of architectural registers, x0 included.
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port arstn_i  input  1  meaning reset, synchronous and active-low, sampled only on the rising edge of clk_i.
REQ-006 SHALL have port wr_en_i  input  1  meaning writeback request.
REQ-007 SHALL have port wr_addr_i  input  GPR_ADDR_WIDTH  meaning writeback register index.
REQ-008 SHALL have port wr_data_i  input  32  meaning writeback data.
REQ-009 SHALL have port r1_addr_i  input  GPR_ADDR_WIDTH  meaning read port 1 index (rs1).
REQ-010 SHALL have port r1_data_o  output  32  meaning read port 1 data.
REQ-011 SHALL have port r2_addr_i  input  GPR_ADDR_WIDTH  meaning read port 2 index (rs2).
REQ-012 SHALL have port r2_data_o  output  32  meaning read port 2 data.
REQ-013 SHALL have port init_done_o  output  1  meaning clear sequence complete; the register file is usable.

Function
REQ-014 SHALL implement an FSM with exactly two states:
- CLEAR: zeroing the register array.
- READY: normal operation.
REQ-015 SHALL, in CLEAR, write 0 to entry clr_cnt each cycle and increment clr_cnt by 1, where clr_cnt is a GPR_ADDR_WIDTH-bit counter.
REQ-016 SHALL transition CLEAR->READY on the cycle clr_cnt==GPR_DEPTH-1; that entry is zeroed in the same cycle; clr_cnt does not wrap to 0.
REQ-017 SHALL complete the clear in exactly GPR_DEPTH-1 cycles: 31 cycles for RISCV_E=0, 15 cycles for RISCV_E=1.
REQ-018 SHALL stay in READY until reset; READY has no exit other than reset.
REQ-019 SHALL drive init_done_o low in CLEAR and high in READY; init_done_o is a registered output.
REQ-020 SHALL ignore wr_en_i entirely in CLEAR; no user write is queued or retained.
REQ-021 SHALL, in READY, write wr_data_i into entry wr_addr_i at the clock edge when wr_en_i=1 and wr_addr_i!=0.
REQ-022 SHALL ignore any write to x0; x0 has no storage and always reads 0.
REQ-023 SHALL provide combinational reads with zero-cycle latency: rN_data_o = entry rN_addr_i.
REQ-024 SHALL bypass a same-cycle write to a read: in READY with wr_en_i=1, wr_addr_i==rN_addr_i and rN_addr_i!=0, rN_data_o = wr_data_i.
REQ-025 SHALL serve both read ports independently; both ports may read the same index, and both are bypassed simultaneously when applicable.
REQ-026 SHALL force r1_data_o and r2_data_o to 0 while in CLEAR, whatever the addresses.
REQ-027 SHALL have no unknown values on any output after the first reset edge.

Reset
REQ-028 SHALL, on a rising edge with arstn_i=0, set state=CLEAR, clr_cnt=1 and init_done_o=0.
REQ-029 SHALL hold these values on every rising edge while arstn_i stays low; CLEAR begins on the first edge with arstn_i=1.
REQ-030 SHALL, on reset asserted mid-CLEAR or in READY, restart the full clear sequence from clr_cnt=1; the array is not required to be cleared by reset itself.
REQ-031 SHALL NOT reset the storage array through arstn_i; the CLEAR sequence is the only initialization path.

Verification
REQ-032 SHALL be verified by the following directed scenarios:
- Reset, RISCV_E=0: arstn_i low for 2 cycles then high -> init_done_o rises exactly 31 cycles after release; then reads of x1..x31 return 0.
- Write/read, RISCV_E=0, READY: write x5=0xDEADBEEF, next cycle r1_addr=5 -> 0xDEADBEEF; write x0=0x12345678 -> r2_addr=0 returns 0.
- Bypass: wr_en_i=1, wr_addr=7, wr_data=0xA5A5A5A5, r1_addr=r2_addr=7 in the same cycle -> both outputs 0xA5A5A5A5 before the edge.
- Write during CLEAR: wr_en_i=1, addr=3, data=0xFFFFFFFF at cycle 5 of CLEAR -> after READY, x3 reads 0 and the read outputs stay 0 throughout CLEAR.
- Reset mid-operation, RISCV_E=0: write x10=0x55, reset asserted at cycle 10 of a second clear -> init_done_o low, rises 31 cycles after release, x10 reads 0.
- RISCV_E=1: reset release -> init_done_o after exactly 15 cycles; x15 is writable and readable; the address ports are 4 bits wide.
